// File: rtl/operand_fwd_pipe_if.sv
// rtl/operand_fwd_pipe_if.sv - operand forwarding pipe bus: decode-side inputs, writeback port, ALU-side outputs.
// OPERANDS_STORE_DATA_EN adds the store_data signal.
interface operand_fwd_pipe_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic [6:0]         opcode;
  logic [RADDR_W-1:0] rs1;
  logic [RADDR_W-1:0] rs2;
  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    imm;
  logic [XLEN-1:0]    rs1d;
  logic [XLEN-1:0]    rs2d;
  logic               wb_we;
  logic [RADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]    wb_data;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    A;
  logic [XLEN-1:0]    B;
`ifdef OPERANDS_STORE_DATA_EN
  logic [XLEN-1:0]    store_data;
`endif

  modport master (
    output in_valid, flush, opcode, rs1, rs2, pc, imm, rs1d, rs2d,
    output wb_we, wb_rd, wb_data, out_ready,
`ifdef OPERANDS_STORE_DATA_EN
    input  store_data,
`endif
    input  in_ready, out_valid, A, B
  );

  modport slave (
    input  in_valid, flush, opcode, rs1, rs2, pc, imm, rs1d, rs2d,
    input  wb_we, wb_rd, wb_data, out_ready,
`ifdef OPERANDS_STORE_DATA_EN
    output store_data,
`endif
    output in_ready, out_valid, A, B
  );
endinterface

// File: rtl/operand_fwd_pipe.sv
// rtl/operand_fwd_pipe.sv - stage-2 operand select with writeback forwarding and a valid/ready output slot.
// OPERANDS_STORE_DATA_EN adds a registered forwarded-rs2 store_data output.
module operand_fwd_pipe #(
  parameter int XLEN       = 32,
  parameter int RADDR_W    = 5,
  parameter int HIST_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  operand_fwd_pipe_if.slave bus
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;

  logic               r_hist_v    [HIST_DEPTH];
  logic [RADDR_W-1:0] r_hist_rd   [HIST_DEPTH];
  logic [XLEN-1:0]    r_hist_data [HIST_DEPTH];

  logic            r_out_valid;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] w_fwd1;
  logic [XLEN-1:0] w_fwd2;
  logic [XLEN-1:0] w_sel_a;
  logic [XLEN-1:0] w_sel_b;
  logic            w_in_ready;
  logic            w_accept;

  assign w_in_ready    = !r_out_valid || bus.out_ready;
  assign w_accept      = bus.in_valid && w_in_ready && !bus.flush;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.A         = r_a;
  assign bus.B         = r_b;

  // Walk oldest to newest so newer matches overwrite; live port is applied last.
  always_comb begin
    w_fwd1 = bus.rs1d;
    w_fwd2 = bus.rs2d;
    for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
      if (r_hist_v[i] && r_hist_rd[i] == bus.rs1 && bus.rs1 != '0) w_fwd1 = r_hist_data[i];
      if (r_hist_v[i] && r_hist_rd[i] == bus.rs2 && bus.rs2 != '0) w_fwd2 = r_hist_data[i];
    end
    if (bus.wb_we && bus.wb_rd == bus.rs1 && bus.rs1 != '0) w_fwd1 = bus.wb_data;
    if (bus.wb_we && bus.wb_rd == bus.rs2 && bus.rs2 != '0) w_fwd2 = bus.wb_data;
  end

  always_comb begin
    w_sel_a = w_fwd1;
    w_sel_b = w_fwd2;
    case (bus.opcode)
      OP_JALR, OP_LUI, OP_STORE, OP_LOAD, OP_ITYPE: w_sel_b = bus.imm;
      OP_JAL, OP_BRANCH, OP_AUIPC: begin
        w_sel_a = bus.pc;
        w_sel_b = bus.imm;
      end
      default: ;
    endcase
  end

  // History ages by cycle: idle cycles push an invalid entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        r_hist_v[i]    <= 1'b0;
        r_hist_rd[i]   <= '0;
        r_hist_data[i] <= '0;
      end
    end else begin
      r_hist_v[0]    <= bus.wb_we && bus.wb_rd != '0;
      r_hist_rd[0]   <= bus.wb_rd;
      r_hist_data[0] <= bus.wb_data;
      for (int i = 1; i < HIST_DEPTH; i++) begin
        r_hist_v[i]    <= r_hist_v[i-1];
        r_hist_rd[i]   <= r_hist_rd[i-1];
        r_hist_data[i] <= r_hist_data[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
    end else begin
      if (w_accept) begin
        r_a <= w_sel_a;
        r_b <= w_sel_b;
      end
      if (bus.flush)          r_out_valid <= 1'b0;
      else if (w_accept)      r_out_valid <= 1'b1;
      else if (bus.out_ready) r_out_valid <= 1'b0;
    end
  end

`ifdef OPERANDS_STORE_DATA_EN
  logic [XLEN-1:0] r_store_data;
  assign bus.store_data = r_store_data;

  always_ff @(posedge clk) begin
    if (reset)         r_store_data <= '0;
    else if (w_accept) r_store_data <= w_fwd2;
  end
`endif
endmodule

// File: tb/tb_operand_fwd_pipe.sv
// tb/tb_operand_fwd_pipe.sv - directed self-checking bench for operand_fwd_pipe.
// Define OPERANDS_STORE_DATA_EN to also exercise store_data.
module tb_operand_fwd_pipe;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
`ifdef OPERANDS_STORE_DATA_EN
  localparam logic [6:0] OP_STORE = 7'b0100011;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  operand_fwd_pipe_if #(.XLEN(32), .RADDR_W(5)) bus ();

  operand_fwd_pipe #(.XLEN(32), .RADDR_W(5), .HIST_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [6:0] op, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] pcv, input logic [31:0] immv);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.rs1      = s1;
    bus.rs2      = s2;
    bus.rs1d     = d1;
    bus.rs2d     = d2;
    bus.pc       = pcv;
    bus.imm      = immv;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    bus.wb_we   = we;
    bus.wb_rd   = rd;
    bus.wb_data = data;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.opcode    = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.pc        = '0;
    bus.imm       = '0;
    bus.rs1d      = '0;
    bus.rs2d      = '0;
    bus.out_ready = 1'b1;
    set_wb(1'b0, 5'd0, 32'h0);
    step();
    step();
    reset = 1'b0;
    #1;
    check_eq("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check_eq("rst_A", bus.A, 32'h0);
    check_eq("rst_B", bus.B, 32'h0);
    check_eq("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);

    // Plain R-type, no hazards
    set_op(OP_RTYPE, 5'd5, 5'd6, 32'd10, 32'd20, 32'h0, 32'h0);
    step();
    check_eq("rtype_valid", {31'b0, bus.out_valid}, 32'h1);
    check_eq("rtype_A", bus.A, 32'd10);
    check_eq("rtype_B", bus.B, 32'd20);

    // Live writeback port forwarding, then x0 never forwards
    set_op(OP_RTYPE, 5'd5, 5'd0, 32'h11, 32'h22, 32'h0, 32'h0);
    set_wb(1'b1, 5'd5, 32'hAA);
    step();
    check_eq("live_A", bus.A, 32'hAA);
    check_eq("live_B_x0", bus.B, 32'h22);
    bus.rs1 = 5'd0;
    set_wb(1'b1, 5'd0, 32'hAA);
    step();
    check_eq("x0_A", bus.A, 32'h11);

    bus.in_valid = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);
    step();
    step();
    check_eq("idle_valid", {31'b0, bus.out_valid}, 32'h0);

    // History: x7=0x33 at t, x7=0x44 at t+1, read at t+2..t+4
    set_wb(1'b1, 5'd7, 32'h33);
    step();
    set_wb(1'b1, 5'd7, 32'h44);
    step();
    set_wb(1'b0, 5'd0, 32'h0);
    set_op(OP_ITYPE, 5'd7, 5'd0, 32'h99, 32'h0, 32'h0, 32'h5);
    step();
    check_eq("hist0_A", bus.A, 32'h44);
    check_eq("itype_B_imm", bus.B, 32'h5);
    step();
    check_eq("hist1_A", bus.A, 32'h44);
    step();
    check_eq("hist_aged_A", bus.A, 32'h99);

    // AUIPC then a 3-cycle stall
    set_op(OP_AUIPC, 5'd1, 5'd2, 32'h1, 32'h2, 32'h2000, 32'h1000);
    step();
    check_eq("auipc_A", bus.A, 32'h2000);
    check_eq("auipc_B", bus.B, 32'h1000);
    bus.out_ready = 1'b0;
    set_op(OP_RTYPE, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 32'h0);
    #1;
    check_eq("stall_in_ready", {31'b0, bus.in_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_A", bus.A, 32'h2000);
      check_eq("stall_B", bus.B, 32'h1000);
      check_eq("stall_valid", {31'b0, bus.out_valid}, 32'h1);
      check_eq("stall_in_ready_hold", {31'b0, bus.in_ready}, 32'h0);
    end
    bus.out_ready = 1'b1;
    #1;
    check_eq("release_in_ready", {31'b0, bus.in_ready}, 32'h1);
    step();
    check_eq("b2b_valid", {31'b0, bus.out_valid}, 32'h1);
    check_eq("b2b_A", bus.A, 32'h1);
    check_eq("b2b_B", bus.B, 32'h2);

    // Flush while stalled, then flush with slot free
    bus.out_ready = 1'b0;
    step();
    bus.flush = 1'b1;
    set_op(OP_RTYPE, 5'd1, 5'd2, 32'h77, 32'h78, 32'h0, 32'h0);
    step();
    check_eq("flush_stall_valid", {31'b0, bus.out_valid}, 32'h0);
    bus.out_ready = 1'b1;
    step();
    check_eq("flush_drop_valid", {31'b0, bus.out_valid}, 32'h0);
    bus.flush = 1'b0;

    // Reset mid-stall discards operands and history
    set_op(OP_RTYPE, 5'd9, 5'd0, 32'h5A, 32'h6B, 32'h0, 32'h0);
    step();
    check_eq("pre_rst_A", bus.A, 32'h5A);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    set_wb(1'b1, 5'd9, 32'hEE);
    step();
    check_eq("pre_rst_hold_A", bus.A, 32'h5A);
    reset = 1'b1;
    set_wb(1'b0, 5'd0, 32'h0);
    step();
    check_eq("midrst_valid", {31'b0, bus.out_valid}, 32'h0);
    check_eq("midrst_A", bus.A, 32'h0);
    check_eq("midrst_B", bus.B, 32'h0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    set_op(OP_RTYPE, 5'd9, 5'd0, 32'h3, 32'h4, 32'h0, 32'h0);
    #1;
    check_eq("postrst_in_ready", {31'b0, bus.in_ready}, 32'h1);
    step();
    check_eq("postrst_hist_clear_A", bus.A, 32'h3);

`ifdef OPERANDS_STORE_DATA_EN
    set_op(OP_STORE, 5'd0, 5'd3, 32'h100, 32'h1, 32'h0, 32'h40);
    set_wb(1'b1, 5'd3, 32'h55);
    step();
    check_eq("store_A", bus.A, 32'h100);
    check_eq("store_B_imm", bus.B, 32'h40);
    check_eq("store_data", bus.store_data, 32'h55);
    set_wb(1'b0, 5'd0, 32'h0);
`endif

    bus.in_valid = 1'b0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
